sc_stream_decoder: RTL
======================

Name: sc_stream_decoder

Overview:
- Receiving end of a stochastic bitstream link: counts the 1s in a unipolar bitstream over a fixed window of 2^WIDTH valid bits and returns the binary estimate.
- Sits downstream of the sng_sc_8bit generators and the AND/MUX compute lanes, and replaces the free-running counter used today.
- Adds start control, a valid-qualified input, a registered result with valid/ready handshake, continuous back-to-back windows, and overrun reporting.

Parameters:
- WIDTH, 8, result width; window length is 2^WIDTH valid input bits.
- CONTINUOUS, 0, 1 = automatically begin the next window after the last bit; 0 = return to IDLE.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; clears the window counters and begins a window.
- bs_in  input  1  stochastic bit.
- bs_valid  input  1  bs_in is valid this cycle.
- bin_out  output  WIDTH  held result, saturated count of 1s.
- out_valid  output  1  bin_out holds an unconsumed result.
- out_ready  input  1  consumer accepts the result when out_valid is also high.
- busy  output  1  high while state is ACCUM.
- overrun  output  1  sticky: a completed result was dropped.

Behaviour:
- Reset (async, any state): state=IDLE; sample_ctr=0; ones_ctr=0; bin_out=0; out_valid=0; busy=0; overrun=0.
- Counter widths:
  - sample_ctr is WIDTH bits.
  - ones_ctr is WIDTH+1 bits, so it can reach 2^WIDTH.
- IDLE:
  - bs_valid is ignored.
  - start -> ACCUM with both counters cleared. overrun is cleared in the same cycle.
- ACCUM, each cycle with bs_valid=1:
  - sample_ctr += 1.
  - ones_ctr += bs_in.
  - bs_valid=0: counters hold; no timeout.
- Window completion: the cycle with bs_valid=1 while sample_ctr == 2^WIDTH-1, i.e. the last bit.
  - The result is ones_ctr + bs_in, saturated to 2^WIDTH-1 when it equals 2^WIDTH.
  - The result is loaded into bin_out and out_valid=1 on the next edge. Latency from last bit to out_valid is 1 cycle.
  - Counters clear.
  - Next state: ACCUM if CONTINUOUS=1, otherwise IDLE.
  - sample_ctr wraps 2^WIDTH-1 -> 0 by this clear, never by overflow.
- start while in ACCUM: restarts the window.
  - Counters clear; the partial window is discarded.
  - The current input bit is discarded, even if bs_valid=1.
  - bin_out and out_valid are untouched.
- Output handshake:
  - out_valid & out_ready consumes the result: out_valid falls next cycle, bin_out holds its value.
  - bin_out is stable while out_valid=1 and out_ready=0.
- Completion while out_valid=1 and out_ready=0: the new result is dropped. bin_out keeps the old value and overrun is set. overrun stays set until start or rst.
- Completion in the same cycle as a consume (out_valid & out_ready): the new result loads, out_valid stays 1, no overrun.
- start and window completion in the same cycle: start wins. No result is produced and counters clear.
- busy is combinational: busy = (state == ACCUM).
- Reset mid-window: everything is lost, including any pending result.

Decomposition:
- Shared package sc_pkg holds:
  - the state encoding, with values IDLE=0, ACCUM=1;
  - a function sc_sat(count, width) implementing the saturation rule, shared with future bipolar decoders.
- One natural sub-module, sc_window_ctr:
  - a WIDTH-bit sample counter with clear, enable and a last-bit flag (sample_ctr == max);
  - instantiated once.
- The ones accumulator and the output register stay in the top level.

Test Plan (WIDTH=4, window of 16 bits, unless noted):
- Reset, start, then 16 valid bits with 6 ones, out_ready=1 -> out_valid pulses for 1 cycle, 1 cycle after the 16th bit, with bin_out=6. Next state is IDLE, busy=0.
- All-ones window -> bin_out=15 (saturated). All-zeros window -> bin_out=0.
- 16 valid bits interleaved with bs_valid=0 gaps (bits carried on the gap cycles are forced to 1) -> bin_out counts only the valid ones. Completion comes only after the 16th valid bit.
- CONTINUOUS=1, out_ready=0, two windows producing 5 then 9 -> bin_out stays 5 and overrun=1. Then out_ready=1 for one cycle -> out_valid=0. A third window producing 9 -> bin_out=9, overrun still 1 until the next start.
- start after 10 valid bits -> window restarts. 16 further bits with 3 ones -> bin_out=3.
- rst asserted asynchronously mid-window and mid-handshake -> all outputs 0 immediately, without waiting for a clock edge. start in the same cycle as the last bit -> no out_valid.

Source files
------------

// File: rtl/sc_pkg.sv
// sc_pkg: shared decoder state encoding and count saturation helper
package sc_pkg;
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} sc_state_t;
  function automatic logic [31:0] sc_sat(input logic [32:0] count, input int width);
    logic [32:0] max_val;
    max_val = (33'd1 << width) - 33'd1;
    return (count > max_val) ? max_val[31:0] : count[31:0];
  endfunction
endpackage

// File: rtl/sc_window_ctr.sv
// sc_window_ctr: WIDTH-bit valid-sample counter (clk, rst, clr, en in; last out when count is at max)
module sc_window_ctr #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [WIDTH-1:0] sample_ctr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sample_ctr <= '0;
    else if (clr) sample_ctr <= '0;
    else if (en) sample_ctr <= sample_ctr + WIDTH'(1);
  assign last = &sample_ctr;
endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts 1s over 2^WIDTH valid bits (clk/rst, start, bs_in/bs_valid in; bin_out/out_valid/out_ready handshake; busy, overrun out)
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bs_in,
  input  logic             bs_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);
  sc_state_t state, state_nxt;
  logic [WIDTH:0] ones_ctr, ones_nxt;
  logic [WIDTH-1:0] result;
  logic last, take, done, consume, load;
  assign take     = (state == ACCUM) && bs_valid && !start;
  assign done     = take && last;
  assign consume  = out_valid && out_ready;
  assign load     = done && (!out_valid || out_ready);
  assign ones_nxt = ones_ctr + {{WIDTH{1'b0}}, bs_in};
  assign result   = WIDTH'(sc_sat(33'(ones_nxt), WIDTH));
  assign busy     = state == ACCUM;
  always_comb state_nxt = start ? ACCUM : done ? (CONTINUOUS != 0 ? ACCUM : IDLE) : state;
  sc_window_ctr #(.WIDTH(WIDTH)) u_win (
    .clk (clk),
    .rst (rst),
    .clr (start || done),
    .en  (take),
    .last(last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) ones_ctr <= '0;
    else if (start || done) ones_ctr <= '0;
    else if (take) ones_ctr <= ones_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        bin_out   <= result;
        out_valid <= 1'b1;
      end else if (consume) out_valid <= 1'b0;
      overrun <= start ? 1'b0 : (done && !load) ? 1'b1 : overrun;
    end
endmodule
